// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and defaults for the UART blocks
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int MIN_CPB = 4;
    localparam int DEF_CPB_W = 10;
    localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer resetting to 1 (idle serial line)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk)
        if (rst) {m, q} <= 2'b11;
        else     {m, q} <= {d, m};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver with run-time bit period, valid and framing-error strobes
module uart_rx
    import uart_pkg::*;
#(
    parameter int CPB_W = DEF_CPB_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CPB_W-1:0]  clk_per_bit,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DATA_W);
    state_t             state;
    logic               rx_s;
    logic [CPB_W-1:0]   cnt;
    logic [CPB_W-1:0]   n;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  sh;
    sync_2ff u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
    // n is captured at start detection so mid-frame period changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            n         <= '0;
            idx       <= '0;
            sh        <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE:
                    if (!rx_s && clk_per_bit >= CPB_W'(MIN_CPB)) begin
                        state <= START;
                        n     <= clk_per_bit;
                        cnt   <= (clk_per_bit >> 1) - CPB_W'(1);
                        busy  <= 1'b1;
                    end
                START:
                    if (cnt != '0) cnt <= cnt - CPB_W'(1);
                    else if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= DATA;
                        cnt   <= n - CPB_W'(1);
                        idx   <= '0;
                    end
                DATA:
                    if (cnt != '0) cnt <= cnt - CPB_W'(1);
                    else begin
                        sh  <= {rx_s, sh[DATA_W-1:1]};
                        cnt <= n - CPB_W'(1);
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(DATA_W - 1)) state <= STOP;
                    end
                STOP:
                    if (cnt != '0) cnt <= cnt - CPB_W'(1);
                    else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            data  <= sh;
                            valid <= 1'b1;
                        end else frame_err <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector and corner-sequence checks for uart_rx
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b0;
    logic [9:0] clk_per_bit = 10'd16;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    uart_rx dut (
        .clk(clk), .rst(rst), .clk_per_bit(clk_per_bit), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vq[$];
    logic [7:0] dq[$];
    int         fq[$];
    int         busy_cnt = 0;
    bit         both = 1'b0;
    always @(negedge clk) begin
        if (valid) begin
            vq.push_back(cyc);
            dq.push_back(data);
        end
        if (frame_err) fq.push_back(cyc);
        if (busy) busy_cnt++;
        if (valid && frame_err) both = 1'b1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rx changes just after posedge cyc=s; the pulse becomes visible at cyc s + lat(n)
    function automatic int lat(input int n);
        return n / 2 + 9 * n + 3;
    endfunction

    task automatic send_frame(input int n, input logic [7:0] b, input logic stop, output int s);
        s = cyc;
        rx = 1'b0;
        repeat (n) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (n) tick();
        end
        rx = stop;
        repeat (n) tick();
        rx = 1'b1;
    endtask

    typedef struct {
        int         n;
        logic [7:0] b;
        logic       stop;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tv[5];

    initial begin
        int s, s2, nv, nf, b0;
        tv[0] = '{16, 8'hA5, 1'b1, 8'hA5};
        tv[1] = '{16, 8'h3C, 1'b0, 8'hA5};
        tv[2] = '{16, 8'hFF, 1'b1, 8'hFF};
        tv[3] = '{20, 8'h81, 1'b1, 8'h81};
        tv[4] = '{4,  8'h96, 1'b1, 8'h96};

        repeat (3) tick();
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        rx = 1'b1;
        repeat (20) tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_pulses", vq.size() + fq.size(), 0);

        for (int i = 0; i < 5; i++) begin
            clk_per_bit = 10'(tv[i].n);
            nv = vq.size();
            nf = fq.size();
            send_frame(tv[i].n, tv[i].b, tv[i].stop, s);
            repeat (tv[i].n + 4) tick();
            chk($sformatf("vec%0d_valid_cnt", i), vq.size() - nv, tv[i].stop ? 1 : 0);
            chk($sformatf("vec%0d_ferr_cnt", i), fq.size() - nf, tv[i].stop ? 0 : 1);
            if (tv[i].stop && vq.size() > nv)
                chk($sformatf("vec%0d_valid_cyc", i), vq[$] - s, lat(tv[i].n));
            if (!tv[i].stop && fq.size() > nf)
                chk($sformatf("vec%0d_ferr_cyc", i), fq[$] - s, lat(tv[i].n));
            chk($sformatf("vec%0d_data", i), data, tv[i].exp_data);
            chk($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // false start: low for fewer cycles than half a bit
        clk_per_bit = 10'd32;
        nv = vq.size();
        nf = fq.size();
        b0 = busy_cnt;
        rx = 1'b0;
        repeat (10) tick();
        rx = 1'b1;
        repeat (60) tick();
        chk("glitch_busy_cycles", busy_cnt - b0, 16);
        chk("glitch_pulses", vq.size() + fq.size() - nv - nf, 0);

        // back-to-back frames; period wiggles mid-frame and is restored before the second start
        clk_per_bit = 10'd8;
        nv = vq.size();
        fork
            begin
                send_frame(8, 8'h00, 1'b1, s);
                send_frame(8, 8'hFF, 1'b1, s2);
            end
            begin
                repeat (20) tick();
                clk_per_bit = 10'd12;
                repeat (40) tick();
                clk_per_bit = 10'd8;
            end
        join
        repeat (12) tick();
        chk("b2b_cnt", vq.size() - nv, 2);
        if (vq.size() - nv == 2) begin
            chk("b2b_cyc0", vq[nv] - s, lat(8));
            chk("b2b_data0", dq[nv], 8'h00);
            chk("b2b_cyc1", vq[nv+1] - s2, lat(8));
            chk("b2b_data1", dq[nv+1], 8'hFF);
        end
        clk_per_bit = 10'd12;
        nv = vq.size();
        send_frame(12, 8'h5A, 1'b1, s);
        repeat (16) tick();
        chk("n12_cnt", vq.size() - nv, 1);
        if (vq.size() > nv) chk("n12_cyc", vq[$] - s, lat(12));
        chk("n12_data", data, 8'h5A);

        // reset while in DATA
        clk_per_bit = 10'd16;
        nv = vq.size();
        nf = fq.size();
        rx = 1'b0;
        repeat (40) tick();
        chk("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_busy_after", busy, 1'b0);
        rx = 1'b1;
        rst = 1'b0;
        repeat (200) tick();
        chk("mid_pulses", vq.size() + fq.size() - nv - nf, 0);
        send_frame(16, 8'h55, 1'b1, s);
        repeat (20) tick();
        chk("post_rst_cnt", vq.size() - nv, 1);
        if (vq.size() > nv) chk("post_rst_cyc", vq[$] - s, lat(16));
        chk("post_rst_data", data, 8'h55);

        // periods below the minimum keep the receiver idle
        b0 = busy_cnt;
        nv = vq.size();
        nf = fq.size();
        for (int p = 0; p < 4; p++) begin
            clk_per_bit = 10'(p);
            for (int i = 0; i < 40; i++) begin
                rx = ~rx;
                repeat (1 + (i % 3)) tick();
            end
        end
        rx = 1'b1;
        repeat (10) tick();
        chk("slow_cpb_busy", busy_cnt - b0, 0);
        chk("slow_cpb_pulses", vq.size() + fq.size() - nv - nf, 0);
        chk("never_both", both, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
